// File: rtl/irrigation_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : irrigation_pkg
//  Purpose : Shared definitions for the irrigation scheduler: parameter
//            defaults, sensor bit positions, irrigation FSM state encoding
//            and a small elaboration-time helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package irrigation_pkg;

  // Parameter defaults
  localparam int unsigned c_debounce_def  = 4;
  localparam int unsigned c_min_on_def    = 8;
  localparam int unsigned c_max_irrig_def = 32;
  localparam int unsigned c_rest_def      = 16;

  // Sensor vector layout (one debounce channel per bit)
  localparam int unsigned c_num_sensors = 6;
  localparam int unsigned c_sns_low     = 0;
  localparam int unsigned c_sns_mid     = 1;
  localparam int unsigned c_sns_high    = 2;
  localparam int unsigned c_sns_us      = 3;
  localparam int unsigned c_sns_ua      = 4;
  localparam int unsigned c_sns_t       = 5;

  // Irrigation FSM state encoding (also visible on the state output)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ASP_ON = 3'd1,
    ST_GOT_ON = 3'd2,
    ST_REST   = 3'd3,
    ST_FAULT  = 3'd4
  } irr_state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irrigation_scheduler_sensor_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : sensor_debounce
//  Purpose : Two-flop synchronizer followed by a debounce filter. The
//            filtered output only changes after DEBOUNCE consecutive
//            synchronized samples that all disagree with it.
//  Ports   : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            raw      - asynchronous sensor input
//            filtered - debounced, synchronized sensor value
//  Rev     : 1.0  initial release
// ============================================================================
module sensor_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered
);

  localparam int unsigned c_cnt_w = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;

  // r_cnt holds how many consecutive samples already disagreed with the
  // filtered value; the DEBOUNCE-th disagreeing sample commits the change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      filtered <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == filtered) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        filtered <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irrigation_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : irrigation_scheduler
//  Purpose : Tank fill controller with hysteresis running alongside an
//            irrigation FSM (IDLE / ASP_ON / GOT_ON / REST / FAULT). All
//            sensors are synchronized and debounced; outputs are registered
//            from the next-state decode so they follow a filtered change by
//            one cycle.
//  Config  : IRRIG_WATCHDOG_EN - when defined, a run lasting MAX_IRRIG
//            cycles is stopped and the FSM rests for REST cycles.
//  Ports   : clk, rst_n             - clock, asynchronous active-low reset
//            low, mid, high         - tank level sensors (1 = water present)
//            Us, Ua, T              - soil wet, air humid, temperature high
//            clear_fault            - single-cycle fault acknowledge
//            watter_supply          - tank fill valve
//            asp, got               - sprinkler / drip irrigation enables
//            error, alarme          - fault indicators
//            state                  - current FSM state encoding
//  Rev     : 1.0  initial release
// ============================================================================
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = c_debounce_def,
  parameter int unsigned MIN_ON    = c_min_on_def,
  parameter int unsigned MAX_IRRIG = c_max_irrig_def,
  parameter int unsigned REST      = c_rest_def
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       low,
  input  logic       mid,
  input  logic       high,
  input  logic       Us,
  input  logic       Ua,
  input  logic       T,
  input  logic       clear_fault,
  output logic       watter_supply,
  output logic       asp,
  output logic       got,
  output logic       error,
  output logic       alarme,
  output logic [2:0] state
);

  // One saturating counter times both the run length and the rest period.
  localparam int unsigned c_cnt_max = max3(MIN_ON, MAX_IRRIG, REST);
  localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(c_cnt_max);
  localparam logic [c_cnt_w-1:0] c_min_on  = c_cnt_w'(MIN_ON);
`ifdef IRRIG_WATCHDOG_EN
  localparam logic [c_cnt_w-1:0] c_max_irrig = c_cnt_w'(MAX_IRRIG);
  localparam logic [c_cnt_w-1:0] c_rest      = c_cnt_w'(REST);
`endif

  logic [c_num_sensors-1:0] w_raw;
  logic [c_num_sensors-1:0] w_filt;
  logic                     w_low, w_mid, w_high, w_us, w_ua, w_t;
  logic                     w_incons;
  irr_state_t               r_state;
  irr_state_t               w_state_nxt;
  logic [c_cnt_w-1:0]       r_cnt;

  assign w_raw = {T, Ua, Us, high, mid, low};

  for (genvar i = 0; i < c_num_sensors; i++) begin : g_sensor
    sensor_debounce #(
      .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (w_raw[i]),
      .filtered (w_filt[i])
    );
  end

  assign w_low  = w_filt[c_sns_low];
  assign w_mid  = w_filt[c_sns_mid];
  assign w_high = w_filt[c_sns_high];
  assign w_us   = w_filt[c_sns_us];
  assign w_ua   = w_filt[c_sns_ua];
  assign w_t    = w_filt[c_sns_t];

  // A higher sensor wet while a lower one is dry means a broken sensor.
  assign w_incons = (w_high & ~w_mid) | (w_mid & ~w_low);

  always_comb begin
    w_state_nxt = r_state;
    if (w_incons) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_us && w_mid) begin
            w_state_nxt = (w_t || !w_ua) ? ST_GOT_ON : ST_ASP_ON;
          end
        end
        ST_ASP_ON, ST_GOT_ON: begin
          // Empty tank stops the run at once; wet soil only after MIN_ON.
          if (!w_low) begin
            w_state_nxt = ST_IDLE;
          end else if (w_us && (r_cnt >= c_min_on)) begin
            w_state_nxt = ST_IDLE;
          end
`ifdef IRRIG_WATCHDOG_EN
          else if (r_cnt >= c_max_irrig) begin
            w_state_nxt = ST_REST;
          end
`endif
        end
`ifdef IRRIG_WATCHDOG_EN
        ST_REST: begin
          if (r_cnt >= c_rest) begin
            w_state_nxt = ST_IDLE;
          end
        end
`endif
        ST_FAULT: begin
          if (clear_fault) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // r_cnt is 1 during the first cycle of a state, so it counts the cycles
  // spent in the current run or rest including the present one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      watter_supply <= 1'b0;
      asp           <= 1'b0;
      got           <= 1'b0;
      error         <= 1'b0;
      alarme        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= c_cnt_w'(1);
      end else if (r_cnt != c_cnt_sat) begin
        r_cnt <= r_cnt + 1'b1;
      end
      asp    <= (w_state_nxt == ST_ASP_ON);
      got    <= (w_state_nxt == ST_GOT_ON);
      error  <= (w_state_nxt == ST_FAULT);
      alarme <= (w_state_nxt == ST_FAULT);
      // Fill hysteresis: start below mid, stop at high, hold in between.
      if (w_state_nxt == ST_FAULT) begin
        watter_supply <= 1'b0;
      end else if (!w_mid) begin
        watter_supply <= 1'b1;
      end else if (w_high) begin
        watter_supply <= 1'b0;
      end
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_irrigation_scheduler
//  Purpose : Self-checking bench for irrigation_scheduler with a behavioural
//            reference model (input history queue + rule-based FSM).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_irrigation_scheduler;
  import irrigation_pkg::*;

  localparam int D         = 4;
  localparam int MIN_ON    = 8;
  localparam int MAX_IRRIG = 32;
  localparam int REST      = 16;
`ifdef IRRIG_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int B_LOW = 0, B_MID = 1, B_HIGH = 2, B_US = 3, B_UA = 4, B_T = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic low = 1'b0, mid = 1'b0, high = 1'b0, Us = 1'b0, Ua = 1'b0, T = 1'b0;
  logic clear_fault = 1'b0;
  logic watter_supply, asp, got, error, alarme;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irrigation_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .low           (low),
    .mid           (mid),
    .high          (high),
    .Us            (Us),
    .Ua            (Ua),
    .T             (T),
    .clear_fault   (clear_fault),
    .watter_supply (watter_supply),
    .asp           (asp),
    .got           (got),
    .error         (error),
    .alarme        (alarme),
    .state         (state)
  );

  // ---------------- reference model ----------------
  bit [5:0]   hist[$];   // sensor vector sampled at every clock edge
  bit [5:0]   m_filt;
  irr_state_t m_st;
  int         m_len;     // cycles spent in the current state
  bit         m_ws, m_asp, m_got, m_err;

  task automatic model_reset();
    hist.delete();
    repeat (D + 2) hist.push_back(6'b0);
    m_filt = '0; m_st = ST_IDLE; m_len = 0;
    m_ws = 0; m_asp = 0; m_got = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit [5:0]   cur, nf;
    bit         inc, all_flip;
    irr_state_t nxt;
    cur = {T, Ua, Us, high, mid, low};
    inc = (m_filt[B_HIGH] && !m_filt[B_MID]) || (m_filt[B_MID] && !m_filt[B_LOW]);
    nxt = m_st;
    if (inc) nxt = ST_FAULT;
    else begin
      case (m_st)
        ST_FAULT: if (clear_fault) nxt = ST_IDLE;
        ST_IDLE:
          if (!m_filt[B_US] && m_filt[B_MID])
            nxt = (m_filt[B_T] || !m_filt[B_UA]) ? ST_GOT_ON : ST_ASP_ON;
        ST_ASP_ON, ST_GOT_ON: begin
          if (!m_filt[B_LOW]) nxt = ST_IDLE;
          else if (m_filt[B_US] && m_len >= MIN_ON) nxt = ST_IDLE;
          else if (WD && m_len >= MAX_IRRIG) nxt = ST_REST;
        end
        ST_REST: if (m_len >= REST) nxt = ST_IDLE;
        default: nxt = ST_IDLE;
      endcase
    end
    m_len = (nxt == m_st) ? m_len + 1 : 1;
    m_st  = nxt;
    m_asp = (nxt == ST_ASP_ON);
    m_got = (nxt == ST_GOT_ON);
    m_err = (nxt == ST_FAULT);
    if (nxt == ST_FAULT) m_ws = 0;
    else if (!m_filt[B_MID]) m_ws = 1;
    else if (m_filt[B_HIGH]) m_ws = 0;
    // Filter window: samples taken 2..D+1 edges ago must all disagree.
    nf = m_filt;
    for (int b = 0; b < 6; b++) begin
      all_flip = 1;
      for (int k = 0; k < D; k++)
        if (hist[hist.size() - 2 - k][b] == m_filt[b]) all_flip = 0;
      if (all_flip) nf[b] = ~m_filt[b];
    end
    m_filt = nf;
    hist.push_back(cur);
    if (hist.size() > D + 4) void'(hist.pop_front());
  endtask

  function automatic logic [7:0] exp_vec();
    return {m_ws, m_asp, m_got, m_err, m_err, m_st};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {watter_supply, asp, got, error, alarme, state};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #2;
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++; $display("FAIL reset_async got=%b exp=%b", dut_vec(), 8'h00);
    end
    tick(); tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_held got=%b exp=%b", dut_vec(), exp_vec());
    end
    rst_n = 1;
  endtask

  task automatic test_fill();
    low = 0; mid = 0; high = 0; Us = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL fill_empty c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (watter_supply !== 1'b1) begin
      errors++; $display("FAIL fill_on_at_7 got=%b exp=1", watter_supply);
    end
    low = 1; mid = 1; high = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL fill_full c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (c == 6) begin
        checks++;
        if (watter_supply !== 1'b1) begin
          errors++; $display("FAIL fill_hold_6 got=%b exp=1", watter_supply);
        end
      end
    end
    checks++;
    if (watter_supply !== 1'b0) begin
      errors++; $display("FAIL fill_off_at_7 got=%b exp=0", watter_supply);
    end
  endtask

  task automatic test_got_min_on();
    int ngot = 0, nasp = 0;
    Us = 0; T = 1; Ua = 1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL got_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (got) ngot++;
      if (asp) nasp++;
      if (c == 4) Us = 1;   // soil turns wet early in the run
    end
    checks++;
    if (ngot != MIN_ON || nasp != 0) begin
      errors++; $display("FAIL got_min_on got_cycles=%0d asp_cycles=%0d exp=%0d/0", ngot, nasp, MIN_ON);
    end
    checks++;
    if (state !== 3'(ST_IDLE)) begin
      errors++; $display("FAIL got_end_idle got=%0d exp=%0d", state, ST_IDLE);
    end
  endtask

  task automatic test_asp_low();
    int nasp = 0, ngot = 0;
    Us = 0; T = 0; Ua = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL asp_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (asp) nasp++;
      if (got) ngot++;
      if (c == 3) begin low = 0; mid = 0; high = 0; end
    end
    checks++;
    if (nasp != 3 || ngot != 0) begin
      errors++; $display("FAIL asp_low_stop asp_cycles=%0d got_cycles=%0d exp=3/0", nasp, ngot);
    end
  endtask

  task automatic test_fault();
    Us = 1; low = 1; mid = 0; high = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL fault_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (c == 6) begin
        checks++;
        if (error !== 1'b0) begin
          errors++; $display("FAIL fault_early got=%b exp=0", error);
        end
      end
    end
    checks++;
    if ({error, alarme, watter_supply, asp, got, state} !== {5'b11000, 3'(ST_FAULT)}) begin
      errors++; $display("FAIL fault_enter got=%b exp=%b", {error, alarme, watter_supply, asp, got, state},
                         {5'b11000, 3'(ST_FAULT)});
    end
    clear_fault = 1; tick(); clear_fault = 0; tick();
    checks++;
    if (state !== 3'(ST_FAULT) || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL fault_clear_ignored got=%b exp=%b", dut_vec(), exp_vec());
    end
    mid = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL fault_fixed c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
    clear_fault = 1; tick(); clear_fault = 0;
    checks++;
    if (state !== 3'(ST_IDLE) || error !== 1'b0 || alarme !== 1'b0) begin
      errors++; $display("FAIL fault_exit state=%0d err=%b al=%b exp=%0d/0/0", state, error, alarme, ST_IDLE);
    end
  endtask

  task automatic test_watchdog();
    int runlen = 0, restn = 0;
    bit fell = 0, again = 0;
    Us = 0; T = 0; Ua = 1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL wd_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (asp) begin
        if (!fell) runlen++;
        else again = 1;
      end else if (runlen > 0) fell = 1;
      if (state === 3'(ST_REST)) restn++;
    end
    checks++;
    if (WD) begin
      if (runlen != MAX_IRRIG || restn != REST || !again) begin
        errors++; $display("FAIL wd_on run=%0d rest=%0d restart=%0d exp=%0d/%0d/1", runlen, restn, again, MAX_IRRIG, REST);
      end
    end else begin
      if (fell || restn != 0 || asp !== 1'b1) begin
        errors++; $display("FAIL wd_off fell=%0d rest=%0d asp=%b exp=0/0/1", fell, restn, asp);
      end
    end
  endtask

  task automatic test_async_reset();
    Us = 1; low = 0; mid = 0; high = 0;
    repeat (8) tick();
    low = 1; mid = 1; Us = 0; T = 0; Ua = 1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL arst_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (asp !== 1'b1 || watter_supply !== 1'b1) begin
      errors++; $display("FAIL arst_setup asp=%b ws=%b exp=1/1", asp, watter_supply);
    end
    #3 rst_n = 0;
    #1;
    checks++;
    if ({asp, got, watter_supply, state} !== {3'b000, 3'(ST_IDLE)}) begin
      errors++; $display("FAIL arst_drop got=%b exp=%b", {asp, got, watter_supply, state}, {3'b000, 3'(ST_IDLE)});
    end
    model_reset();
    tick(); tick();
    rst_n = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || asp !== 1'b0) begin
        errors++; $display("FAIL arst_no_resume c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    bit [2:0] lv;
    for (int c = 1; c <= 500; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 4))
          0: lv = 3'b000;
          1: lv = 3'b001;
          2: lv = 3'b011;
          3: lv = 3'b111;
          default: lv = 3'($urandom_range(0, 7));
        endcase
        {high, mid, low} = lv;
        Us = 1'($urandom_range(0, 1));
        Ua = 1'($urandom_range(0, 1));
        T  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      clear_fault = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
    clear_fault = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_got_min_on();
    test_asp_low();
    test_fault();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
